// File: rtl/regdest_sel_pipe.sv
// Single registered select stage: forwards the operand or a programmable constant
// slot chosen by in_sel, flags out-of-range codes and keeps a saturating error count.
module regdest_sel_pipe #(
  parameter int WIDTH     = 16,
  parameter int SEL_W     = 4,
  parameter int NUM_CONST = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  output logic [7:0]       err_count
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_CONST);

  logic [WIDTH-1:0] tbl [1:NUM_CONST];
  logic [WIDTH-1:0] sel_val;
  logic             sel_err;
  logic             accept;

  // Power-on constants; WIDTH'() zero-extends or truncates to the data width.
  function automatic logic [WIDTH-1:0] reset_val(input int k);
    int v;
    case (k)
      2:       v = 1;
      3:       v = 2;
      4:       v = 3;
      5:       v = 4;
      6:       v = 6;
      7:       v = 7;
      8:       v = 8;
      9:       v = 9;
      10:      v = 15;
      11:      v = 5;
      default: v = 0;
    endcase
    return WIDTH'(v);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sel_err = (in_sel > MAX_SEL);
    sel_val = (in_sel == '0) ? in_data : '0;
    for (int k = 1; k <= NUM_CONST; k++) begin
      if (in_sel == SEL_W'(k)) sel_val = tbl[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      err_count <= 8'd0;
      for (int k = 1; k <= NUM_CONST; k++) tbl[k] <= reset_val(k);
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_err ? '0 : sel_val;
        out_err   <= sel_err;
        if (sel_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // Table reads above see the pre-edge value, so a same-edge write lands next beat.
      for (int k = 1; k <= NUM_CONST; k++) begin
        if (wr_en && wr_idx == SEL_W'(k)) tbl[k] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_regdest_sel_pipe.sv
// Bench for regdest_sel_pipe: a negedge monitor models the table and scoreboards every
// transfer; scenario tasks add targeted inline checks.
module tb_regdest_sel_pipe;
  localparam int WIDTH     = 16;
  localparam int SEL_W     = 4;
  localparam int NUM_CONST = 11;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] in_sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             wr_en;
  logic [SEL_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [7:0]       err_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH:0]   sb_q [$];
  logic [WIDTH-1:0] mtbl [16];
  int               model_err = 0;

  regdest_sel_pipe #(.WIDTH(WIDTH), .SEL_W(SEL_W), .NUM_CONST(NUM_CONST)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .err_count(err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic init_model();
    int rv [12];
    rv = '{0, 0, 1, 2, 3, 4, 6, 7, 8, 9, 15, 5};
    for (int i = 0; i < 16; i++) begin
      mtbl[i] = '0;
      if (i >= 1 && i <= 11) mtbl[i] = WIDTH'(rv[i]);
    end
  endtask

  // Inputs are driven just after posedge; the negedge view is what the next edge sees.
  always @(negedge clk) begin
    logic [WIDTH:0] exp_v;
    logic [WIDTH:0] got_v;
    n_checks++;
    if (err_count !== 8'(model_err)) begin
      n_fail++;
      $display("FAIL err_count_track: got %0d expected %0d at %0t", err_count, model_err, $time);
    end
    if (reset) begin
      sb_q.delete();
      model_err = 0;
      init_model();
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        got_v = {out_err, out_data};
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: got %h with no expected beat at %0t", got_v, $time);
        end else begin
          exp_v = sb_q.pop_front();
          if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL sb_beat: got err=%b data=%h expected err=%b data=%h at %0t",
                     got_v[WIDTH], got_v[WIDTH-1:0], exp_v[WIDTH], exp_v[WIDTH-1:0], $time);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (in_sel == 0)                    exp_v = {1'b0, in_data};
        else if (int'(in_sel) <= NUM_CONST) exp_v = {1'b0, mtbl[in_sel]};
        else begin
          exp_v = {1'b1, {WIDTH{1'b0}}};
          if (model_err != 255) model_err++;
        end
        sb_q.push_back(exp_v);
      end
      if (wr_en && wr_idx >= 1 && int'(wr_idx) <= NUM_CONST) mtbl[wr_idx] = wr_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({out_valid, out_err} !== 2'b00 || out_data !== '0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b e=%b d=%h c=%0d expected 0 0 0000 0",
               out_valid, out_err, out_data, err_count);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_const_stream(input logic [WIDTH-1:0] d);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    for (int s = 0; s <= 11; s++) begin
      in_sel = SEL_W'(s);
      tick();
      if (s == 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_err !== 1'b0) begin
          n_fail++;
          $display("FAIL stream_latency: got v=%b d=%h e=%b expected 1 %h 0",
                   out_valid, out_data, out_err, d);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_err_sat();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int s = 12; s <= 15; s++) begin
      in_sel = SEL_W'(s);
      tick();
      n_checks++;
      if (out_err !== 1'b1 || out_data !== '0) begin
        n_fail++;
        $display("FAIL err_beat: got e=%b d=%h expected 1 0000", out_err, out_data);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (err_count !== 8'd4) begin
      n_fail++;
      $display("FAIL err_count_4: got %0d expected 4", err_count);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_sel = SEL_W'(12 + (i % 4));
      tick();
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (err_count !== 8'd255) begin
      n_fail++;
      $display("FAIL err_count_sat: got %0d expected 255", err_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = '0;
    in_data   = 16'h1234;
    tick();
    in_sel  = SEL_W'(5);
    in_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_data !== 16'h1234 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: got d=%h rdy=%b v=%b expected 1234 0 1",
                 out_data, in_ready, out_valid);
      end
      tick();
    end
    out_ready = 1'b1;
    in_sel    = SEL_W'(2);
    tick();
    n_checks++;
    if (out_data !== 16'h0001 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL back_to_back: got d=%h v=%b expected 0001 1", out_data, out_valid);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_rbw();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = SEL_W'(3);
    wr_en     = 1'b1;
    wr_idx    = SEL_W'(3);
    wr_data   = 16'hBEEF;
    tick();
    n_checks++;
    if (out_data !== 16'h0002) begin
      n_fail++;
      $display("FAIL rbw_old: got %h expected 0002", out_data);
    end
    wr_en = 1'b0;
    tick();
    n_checks++;
    if (out_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rbw_new: got %h expected BEEF", out_data);
    end
    in_valid = 1'b0;
    wr_en    = 1'b1;
    wr_idx   = '0;
    wr_data  = 16'hDEAD;
    tick();
    wr_idx = SEL_W'(13);
    tick();
    wr_en = 1'b0;
    test_const_stream(16'h0F0F);
  endtask

  task automatic test_reset_held();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = SEL_W'(3);
    tick();
    in_valid = 1'b0;
    wr_en    = 1'b1;
    wr_idx   = SEL_W'(7);
    wr_data  = 16'h7777;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (out_data !== 16'hBEEF || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL held_before_reset: got d=%h v=%b expected BEEF 1", out_data, out_valid);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || err_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_discard: got v=%b c=%0d expected 0 0", out_valid, err_count);
    end
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = SEL_W'(3);
    tick();
    n_checks++;
    if (out_data !== 16'h0002) begin
      n_fail++;
      $display("FAIL slot3_restored: got %h expected 0002", out_data);
    end
    in_sel = SEL_W'(7);
    tick();
    n_checks++;
    if (out_data !== 16'h0007) begin
      n_fail++;
      $display("FAIL slot7_restored: got %h expected 0007", out_data);
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    out_ready = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    init_model();
    test_reset();
    test_const_stream(16'hA5A5);
    test_err_sat();
    test_backpressure();
    test_rbw();
    test_reset_held();
    tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending beats expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regdest_sel_pipe.md
REGDEST_SEL_PIPE -- requirements
Module: regdest_sel_pipe

Interface
REQ-001 Parameter WIDTH, default 16, data path and constant width in bits.
REQ-002 Parameter SEL_W, default 4, width of the selection code.
REQ-003 Parameter NUM_CONST, default 11, number of programmable constant slots, indexed 1..NUM_CONST; NUM_CONST SHALL be at most 2**SEL_W-1.
REQ-004 clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream beat present.
REQ-007 in_ready  output  1  block accepts the upstream beat this cycle.
REQ-008 in_data  input  WIDTH  pass-through operand.
REQ-009 in_sel  input  SEL_W  selection code; 0 selects in_data, k in 1..NUM_CONST selects constant slot k.
REQ-010 out_valid  output  1  registered result present.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  WIDTH  registered selected value.
REQ-013 out_err  output  1  registered flag: the beat's in_sel exceeded NUM_CONST.
REQ-014 wr_en  input  1  constant-table write strobe.
REQ-015 wr_idx  input  SEL_W  slot to write.
REQ-016 wr_data  input  WIDTH  value to write.
REQ-017 err_count  output  8  saturating count of accepted out-of-range beats.

Function
REQ-018 The block SHALL be a single registered stage; a beat is accepted when in_valid and in_ready are both 1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-020 On acceptance, out_data, out_err and out_valid=1 SHALL load on the same edge, giving a latency of one cycle.
REQ-021 When out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable until the transfer completes.
REQ-022 out_valid SHALL clear after a transfer (out_valid && out_ready) with no simultaneous acceptance; a simultaneous acceptance SHALL keep out_valid=1 and load the new beat.
REQ-023 in_sel=0 SHALL load in_data; in_sel=k in 1..NUM_CONST SHALL load table slot k.
REQ-024 in_sel>NUM_CONST SHALL load out_data=0 and out_err=1; out_err SHALL be 0 for every other selection.
REQ-025 The table SHALL hold NUM_CONST registers of WIDTH bits each; wr_en with wr_idx in 1..NUM_CONST SHALL update that slot on the edge.
REQ-026 Writes with wr_idx=0 or wr_idx>NUM_CONST SHALL be ignored without any side effect.
REQ-027 Writes SHALL proceed independently of the handshake, including while out_valid=1 and out_ready=0.
REQ-028 An acceptance and a write to the same slot on the same edge SHALL load the old slot value (read-before-write); the new value SHALL apply from the next acceptance onward.
REQ-029 err_count SHALL increment by 1 on each accepted beat with out_err set and SHALL saturate at 255.
REQ-030 Table reset values SHALL be WIDTH-zero-extended; if WIDTH<4, the reset values SHALL be truncated to WIDTH bits.

Reset
REQ-031 While reset=1, outputs SHALL be: out_valid=0, out_data=0, out_err=0, err_count=0.
REQ-032 While reset=1, the table SHALL load slots 1..11 with 0,1,2,3,4,6,7,8,9,15,5.
REQ-033 Slots beyond 11 SHALL reset to 0.
REQ-034 Reset SHALL take priority over acceptance and writes on the same edge.
REQ-035 Reset SHALL discard any held beat.
REQ-036 in_ready SHALL be 1 in the cycle after reset deasserts.

Verification
REQ-037 Reset, then stream in_sel=0..11 with in_data=16'hA5A5 and out_ready=1 -> out_data one cycle later = A5A5,0,1,2,3,4,6,7,8,9,F,5, all with out_err=0.
REQ-038 in_sel=12..15 with out_ready=1 -> out_data=0, out_err=1, err_count=4; then 260 such beats -> err_count holds at 255.
REQ-039 Accept in_sel=0 with in_data=16'h1234, then hold out_ready=0 for 3 cycles -> out_data stays 1234 and in_ready=0; then out_ready=1 with a new beat in_sel=2 -> next cycle out_data=1, out_valid=1.
REQ-040 Same-edge write wr_idx=3, wr_data=16'hBEEF with acceptance of in_sel=3 -> out_data=2; the next in_sel=3 beat -> BEEF; writes to wr_idx=0 and wr_idx=13 -> no observable change.
REQ-041 Assert reset while out_valid=1, out_ready=0 and slot 3=BEEF -> next cycle out_valid=0, err_count=0; a subsequent in_sel=3 beat -> out_data=2.
